// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if
//   Bundles the display-facing signals of the seven-segment scanner.
//   master : the clock/stopwatch datapath; drives digits and masks, observes pins.
//   slave  : the scanner itself; consumes digits/masks, drives an/seg/frame_tick.
//   Signals:
//     digits      4*NUM_DIGITS  nibble i is the hex value of digit i
//     dp          NUM_DIGITS    1 lights the decimal point of digit i
//     blank_mask  NUM_DIGITS    1 forces digit i dark
//     blink_mask  NUM_DIGITS    1 makes digit i follow the blink phase
//     enable      1             0 darkens the whole display
//     an          NUM_DIGITS    active-low anode enables (digit 0 rightmost)
//     seg         8             active-low segments, seg[7]=dp, seg[6:0]=g..a
//     frame_tick  1             one-cycle pulse per completed scan frame
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    enable;
    logic [NUM_DIGITS-1:0]   an;
    logic [7:0]              seg;
    logic                    frame_tick;

    modport master (
        output digits, dp, blank_mask, blink_mask, enable,
        input  an, seg, frame_tick
    );

    modport slave (
        input  digits, dp, blank_mask, blink_mask, enable,
        output an, seg, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A prescaler splits time into REFRESH_DIV-cycle slots, one per digit; the
//   first cycle of every slot is dark to suppress ghosting. A separate blink
//   timebase toggles a phase every BLINK_DIV cycles. Full hex decode with
//   per-digit decimal point, blank and blink masks. All outputs are
//   registered, so an and seg always move on the same edge.
//   Ports:
//     clk  system clock
//     rst  synchronous, active-high reset
//     bus  seven_seg_scan_if.slave (digits/masks in, an/seg/frame_tick out)
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);
    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [BLINK_W-1:0]    blink_cnt_reg, blink_cnt_next;
    logic                  phase_reg, phase_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic [7:0]            seg_reg, seg_next;
    logic                  frame_tick_reg, frame_tick_next;

    logic [3:0]            nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_lit;
    logic [6:0]            seg_lit;
    logic                  dark;

    // Per-digit nibble split and the one-cold anode pattern for the current slot.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble[gi] = bus.digits[4*gi +: 4];
            assign an_lit[gi] = (idx_reg != IDX_W'(gi));
        end
    endgenerate

    // Active-low g..a pattern for one hex digit.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign seg_lit = hex_decode(nibble[idx_reg]);

    // cnt_reg == 0 is the dead-time cycle at the start of every slot.
    assign dark = !bus.enable
               || bus.blank_mask[idx_reg]
               || (bus.blink_mask[idx_reg] && phase_reg)
               || (cnt_reg == '0);

    always_comb begin
        cnt_next        = cnt_reg + 1'b1;
        idx_next        = idx_reg;
        blink_cnt_next  = blink_cnt_reg + 1'b1;
        phase_next      = phase_reg;
        frame_tick_next = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
        an_next         = '1;
        seg_next        = 8'hFF;

        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end

        // Blink timebase runs independently of the prescaler.
        if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end

        if (!dark) begin
            an_next  = an_lit;
            seg_next = {~bus.dp[idx_reg], seg_lit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            an_reg         <= '1;
            seg_reg        <= 8'hFF;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            blink_cnt_reg  <= blink_cnt_next;
            phase_reg      <= phase_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan
//   Self-checking bench for seven_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4,
//   BLINK_DIV=64). Expected outputs come from a timeline model: given the
//   number of clock edges since reset release, slot position, digit index and
//   blink phase follow from plain division/modulo.
module tb_seven_seg_scan;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BD = 64;

    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct {
        logic [15:0] digits;
        int          idx;
        logic [7:0]  seg_exp;
    } hex_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int n      = 0;   // edges since reset release

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (n=%0d)", name, act, exp, n);
        end
    endtask

    // Expected outputs produced by the edge following state index s.
    task automatic model(input int s, input logic [15:0] dg, input logic [3:0] dpv,
                         input logic [3:0] bl, input logic [3:0] bk, input logic en,
                         output logic [3:0] an_e, output logic [7:0] seg_e, output logic ft_e);
        int         pos;
        int         idx;
        int         ph;
        logic [3:0] nib;
        logic [7:0] full;
        pos  = s % RD;
        idx  = (s / RD) % ND;
        ph   = (s / BD) % 2;
        ft_e = ((s % (RD * ND)) == RD * ND - 1);
        an_e  = 4'hF;
        seg_e = 8'hFF;
        if (en && !bl[idx] && !(bk[idx] && ph == 1) && pos != 0) begin
            an_e[idx] = 1'b0;
            nib   = dg[idx*4 +: 4];
            full  = HEX_SEG[nib];
            seg_e = {~dpv[idx], full[6:0]};
        end
    endtask

    // One clock: capture applied inputs, advance, sample #1 after the edge, compare.
    task automatic step();
        logic        r;
        logic [15:0] dg;
        logic [3:0]  dpv, bl, bk;
        logic        en;
        logic [3:0]  an_e;
        logic [7:0]  seg_e;
        logic        ft_e;
        r   = rst;
        dg  = bus.digits;
        dpv = bus.dp;
        bl  = bus.blank_mask;
        bk  = bus.blink_mask;
        en  = bus.enable;
        @(posedge clk);
        #1;
        if (r) begin
            n     = 0;
            an_e  = 4'hF;
            seg_e = 8'hFF;
            ft_e  = 1'b0;
        end else begin
            n++;
            model(n - 1, dg, dpv, bl, bk, en, an_e, seg_e, ft_e);
        end
        chk("scan", 32'({bus.an, bus.seg, bus.frame_tick}), 32'({an_e, seg_e, ft_e}));
        $display("step n=%0d rst=%b en=%b an=%b seg=%h ft=%b", n, r, en, bus.an, bus.seg, bus.frame_tick);
    endtask

    initial begin
        hex_vec_t   vecs [14];
        int         ft_count;
        int         lit_early, lit_late, lit_after, an3_low;
        logic [3:0] an_want;
        logic       found;

        vecs[0]  = '{16'hABCD, 0, 8'hA1};
        vecs[1]  = '{16'hABCD, 1, 8'hC6};
        vecs[2]  = '{16'hABCD, 2, 8'h83};
        vecs[3]  = '{16'hABCD, 3, 8'h88};
        vecs[4]  = '{16'h00EF, 0, 8'h8E};
        vecs[5]  = '{16'h00EF, 1, 8'h86};
        vecs[6]  = '{16'h00EF, 2, 8'hC0};
        vecs[7]  = '{16'h00EF, 3, 8'hC0};
        vecs[8]  = '{16'h5678, 0, 8'h80};
        vecs[9]  = '{16'h5678, 1, 8'hF8};
        vecs[10] = '{16'h5678, 2, 8'h82};
        vecs[11] = '{16'h5678, 3, 8'h92};
        vecs[12] = '{16'h9000, 3, 8'h90};
        vecs[13] = '{16'h0100, 2, 8'hF9};

        bus.digits     = 16'h1234;
        bus.dp         = 4'b0000;
        bus.blank_mask = 4'b0000;
        bus.blink_mask = 4'b0000;
        bus.enable     = 1'b1;

        // Reset held for 3 cycles, then dead time, then digit 0.
        rst = 1'b1;
        repeat (3) begin
            step();
            chk("reset_out", 32'({bus.an, bus.seg, bus.frame_tick}), 32'({4'hF, 8'hFF, 1'b0}));
        end
        rst = 1'b0;
        step();
        chk("post_rst_dark", 32'({bus.an, bus.seg}), 32'({4'hF, 8'hFF}));
        step();
        chk("post_rst_lit", 32'({bus.an, bus.seg}), 32'({4'b1110, 8'h99}));

        // Scan order over one full frame.
        ft_count = 0;
        repeat (16) begin
            step();
            if (bus.frame_tick) ft_count++;
            case (bus.an)
                4'b1110: chk("scan_d0", 32'(bus.seg), 32'h99);
                4'b1101: chk("scan_d1", 32'(bus.seg), 32'hB0);
                4'b1011: chk("scan_d2", 32'(bus.seg), 32'hA4);
                4'b0111: chk("scan_d3", 32'(bus.seg), 32'hF9);
                default: ;
            endcase
        end
        chk("frame_tick_count", 32'(ft_count), 32'd1);

        // Table-driven hex decode.
        for (int v = 0; v < 14; v++) begin
            bus.digits = vecs[v].digits;
            an_want    = 4'hF;
            an_want[vecs[v].idx] = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 2 * ND * RD && !found; k++) begin
                step();
                if (bus.an == an_want) found = 1'b1;
            end
            chk("hex_wait", 32'(found), 32'd1);
            chk("hex_seg", 32'(bus.seg), 32'(vecs[v].seg_exp));
            $display("vec %0d digits=%h idx=%0d seg=%h want=%h", v, vecs[v].digits, vecs[v].idx, bus.seg, vecs[v].seg_exp);
        end

        // Blink, dp, blank from a fresh reset.
        bus.digits     = 16'h1234;
        bus.blink_mask = 4'b0010;
        bus.dp         = 4'b0100;
        bus.blank_mask = 4'b1000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        lit_early = 0; lit_late = 0; lit_after = 0; an3_low = 0;
        repeat (140) begin
            step();
            if (n >= 1 && n <= 64 && !bus.an[1]) lit_early++;
            if (n >= 65 && n <= 128 && !bus.an[1]) lit_late++;
            if (n >= 129 && !bus.an[1]) lit_after++;
            if (!bus.an[3]) an3_low++;
            if (!bus.an[2]) chk("dp_digit2", 32'(bus.seg[7]), 32'd0);
        end
        chk("blink_lit_phase0", 32'(lit_early != 0), 32'd1);
        chk("blink_dark_phase1", 32'(lit_late), 32'd0);
        chk("blink_lit_again", 32'(lit_after != 0), 32'd1);
        chk("blank_digit3", 32'(an3_low), 32'd0);

        // Reset pulse while digit 2 is lit.
        bus.blank_mask = 4'b0000;
        found = 1'b0;
        for (int k = 0; k < 2 * ND * RD && !found; k++) begin
            step();
            if (bus.an == 4'b1011) found = 1'b1;
        end
        chk("midrst_wait", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_dark", 32'({bus.an, bus.seg}), 32'({4'hF, 8'hFF}));
        rst = 1'b0;
        step();
        chk("midrst_dead", 32'({bus.an, bus.seg}), 32'({4'hF, 8'hFF}));
        step();
        chk("midrst_d0", 32'(bus.an), 32'(4'b1110));
        repeat (4) step();
        chk("midrst_phase0_d1", 32'(bus.an), 32'(4'b1101));

        // Enable drop mid-slot; model checks continuity afterwards.
        bus.blink_mask = 4'b0000;
        step();
        bus.enable = 1'b0;
        repeat (10) begin
            step();
            chk("enable_off", 32'({bus.an, bus.seg}), 32'({4'hF, 8'hFF}));
        end
        bus.enable = 1'b1;
        ft_count = 0;
        repeat (32) begin
            step();
            if (bus.frame_tick) ft_count++;
        end
        chk("enable_ft_cadence", 32'(ft_count), 32'd2);

        // Randomised stimulus against the timeline model.
        repeat (500) begin
            bus.digits     = 16'($urandom);
            bus.dp         = 4'($urandom);
            bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus.blink_mask = 4'($urandom);
            bus.enable     = ($urandom_range(0, 7) != 0);
            rst            = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed seven-segment driver for an N-digit common-anode display. It contains its own refresh prescaler and blink timebase, decodes full hex (0-F), and adds per-digit decimal point, blank and blink masks. Anode and segment outputs update on the same clock edge, and each digit slot starts with a one-cycle dead time to suppress ghosting. It sits between the clock/stopwatch datapath and the board's `an`/`seg` pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits/anodes; must be ≥1.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; must be ≥2.
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period; must be ≥1.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `digits` in 4*NUM_DIGITS: nibble i (`[4i+3:4i]`) is the hex value for digit i.
- `dp` in NUM_DIGITS: 1 lights the decimal point of digit i.
- `blank_mask` in NUM_DIGITS: 1 forces digit i dark.
- `blink_mask` in NUM_DIGITS: 1 makes digit i blink using the internal blink phase.
- `enable` in 1: 0 forces the whole display dark; counters keep running.
- `an` out NUM_DIGITS: active-low anode enables; `an[i]` drives digit i, and digit 0 is rightmost.
- `seg` out 8: active-low segments; `seg[7]` is the decimal point, `seg[6:0]` are g..a.
- `frame_tick` out 1: one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

## Operation
- **Prescaler `cnt`** (0..REFRESH_DIV-1)
  - Increments every cycle.
  - At REFRESH_DIV-1 it returns to 0 and the digit index `idx` advances.
  - `idx` counts 0..NUM_DIGITS-1 and wraps to 0. When NUM_DIGITS=1, `idx` stays 0.
- **Blink counter** (0..BLINK_DIV-1)
  - At terminal count it wraps and toggles `phase`.
  - `phase`=1 means blinking digits are dark.
  - Writing `blink_mask` never resets `phase`.
- **Dark digit.** Digit `idx` is dark if any of these holds: `!enable`, `blank_mask[idx]`, `blink_mask[idx] && phase`, or `cnt==0` (dead-time cycle).
- **Dark output.** `an` = all ones, `seg` = 8'hFF.
- **Lit output.**
  - `an` = all ones except bit `idx` = 0.
  - `seg[7]` = `~dp[idx]`.
  - `seg[6:0]` = hex decode of nibble `idx`.
- **Hex decode** (full `seg` value with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- **Input sampling.** Inputs are sampled every cycle and are not latched per slot. A change mid-slot is visible one cycle later.
- **`frame_tick`.** Asserted for the cycle following the `idx` wrap, i.e. on the dead-time cycle of digit 0.

## Timing
- **Output registers.** `an`, `seg` and `frame_tick` are registered. They reflect the state (`cnt`, `idx`, `phase`) and inputs of the previous cycle, so latency is 1 clock.
- **Alignment.** `an` and `seg` always change on the same edge; a segment pattern never appears on a neighbouring anode.
- **Reset values.** While `rst`=1, on every edge:
  - `cnt`=0, `idx`=0, blink counter=0, `phase`=0.
  - `an`=all ones, `seg`=8'hFF, `frame_tick`=0.
- **First cycles after release.** On the first edge after `rst` falls, `cnt` becomes 1 and outputs are dark (dead time for `idx`=0). Digit 0 is lit from the second edge.
- **Slot length.** Each slot is REFRESH_DIV cycles: 1 dark cycle followed by REFRESH_DIV-1 lit cycles.
- **Frame length.** NUM_DIGITS*REFRESH_DIV cycles.
- **Blink period.** `phase` first toggles to 1 after BLINK_DIV cycles; the full blink period is 2*BLINK_DIV.
- **Reset mid-operation.** Outputs go dark on the next edge, and the scan restarts at digit 0 with `phase`=0.
- **Simultaneous events.** A prescaler wrap and a blink toggle on the same cycle are independent; both take effect.
- **Enable toggling.** `enable` low→high resumes mid-slot with no resynchronisation.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=64; `enable`=1 unless stated.
- **Reset.** Hold `rst` for 3 cycles with `digits`=16'h1234 → `an`=4'b1111, `seg`=8'hFF, `frame_tick`=0 throughout. After release, exactly 1 dark cycle, then `an`=1110 with `seg`=99.
- **Scan order.** `digits`=16'h1234, `dp`=0. Each slot is 1 dark cycle + 3 lit cycles:
  - `an`=1110 with `seg`=99
  - then 1101 with B0
  - then 1011 with A4
  - then 0111 with F9
  - `frame_tick` pulses once per 16 cycles.
- **Hex decode.** `digits`=16'hABCD → digit0 `seg`=A1, digit1=C6, digit2=83, digit3=88. Then 16'h00EF → digit0=8E, digit1=86, digit2=C0, digit3=C0.
- **Blink, dp, blank.**
  - Stimulus: `blink_mask`=4'b0010, `dp`=4'b0100, `blank_mask`=4'b1000.
  - `an[1]` never goes low during cycles 64-127 after reset, and lights normally during cycles 0-63.
  - Digit2 shows `seg[7]`=0.
  - `an[3]` never goes low.
- **Reset mid-frame.** Pulse `rst` for 1 cycle while digit 2 is lit → outputs are dark on the next edge. The scan restarts with 1 dark cycle, then `an`=1110, and the blink phase restarts at 0.
- **Enable.** Drop `enable` for 10 cycles mid-slot → outputs are dark (`an`=1111, `seg`=FF) throughout. On re-enable, the scan position continues as if `enable` had never dropped, and `frame_tick` cadence is unchanged.
